uart_transmitter: RTL and testbench

//   Serialises one 8-bit byte per request into an asynchronous UART frame on tx.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_transmitter.sv | 145 ++++++++++++++
 tb/tb_uart_transmitter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: frame levels, data width and FSM state encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int   UART_DATA_W    = 8;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: tick pulses for one clk every DIV clks after clr.
// The counter restarts on clr so a frame's first bit is never shortened.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] di,
  input  logic                   start,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int DIV = CLK_FREQ / BAUD;

  if (DIV < 2) begin : g_div_chk
    $error("uart_transmitter: CLK_FREQ/BAUD must be >= 2");
  end

  uart_state_e            r_state;
  uart_state_e            w_state_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] w_shift_nxt;
  logic [2:0]             r_idx;
  logic                   w_tick;
  logic                   w_accept;
  logic                   w_tx_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
`ifdef UART_TX_PARITY_EN
  logic                   r_par;
`endif

  assign w_accept = (r_state == IDLE) && start;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start)  w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
      DATA: begin
        if (w_tick && r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_state_nxt = STOP;
`endif
      STOP:  if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = di;
    end else if (r_state == DATA && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_idx <= '0;
      end else if (r_state == DATA && w_tick) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^di;
    end
  end
`endif

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (r_state == STOP) && w_tick;
    case (w_state_nxt)
      START:   w_tx_nxt = UART_START_LVL;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_par;
`endif
      default: w_tx_nxt = UART_STOP_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx   <= UART_STOP_LVL;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized self-checking bench for uart_transmitter (DIV=4 and DIV=2).
// Expected line waveform is built from the frame bit list of each byte.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] di1;
  logic       start1;
  logic       tx1;
  logic       busy1;
  logic       done1;
  logic [7:0] di2;
  logic       start2;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int n_chk = 0;
  int n_err = 0;
  int n_done1 = 0;
  int n_done2 = 0;
  int exp_done1 = 0;
  int exp_done2 = 0;

  uart_transmitter #(
    .CLK_FREQ (40),
    .BAUD     (10)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .di    (di1),
    .start (start1),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  uart_transmitter #(
    .CLK_FREQ (2),
    .BAUD     (1)
  ) dut2 (
    .clk   (clk),
    .rst   (rst),
    .di    (di2),
    .start (start2),
    .tx    (tx2),
    .busy  (busy2),
    .done  (done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done1) n_done1++;
    if (done2) n_done2++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == NB - 1) return 1'b1;
    return ^d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin
      start2 = s;
      di2    = d;
    end else begin
      start1 = s;
      di1    = d;
    end
  endtask

  task automatic set_start(input bit sel, input logic s);
    if (sel) start2 = s;
    else     start1 = s;
  endtask

  task automatic set_di(input bit sel, input logic [7:0] d);
    if (sel) di2 = d;
    else     di1 = d;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check({tag, "_tx"},   sel ? tx2   : tx1,   1);
    check({tag, "_busy"}, sel ? busy2 : busy1, 0);
    check({tag, "_done"}, sel ? done2 : done1, 0);
  endtask

  task automatic idle(input bit sel, input int n);
    set_start(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      check_idle(sel, "idle");
    end
  endtask

  // Request a frame now, then check every clk up to and including done.
  task automatic run_frame(input bit sel, input logic [7:0] d,
                           input bit hold, input int mid_k,
                           input logic [7:0] mid_d);
    int div;
    div = sel ? 2 : 4;
    drive(sel, 1'b1, d);
    step();
    for (int k = 0; k < NB * div; k++) begin
      check("frame_tx",   sel ? tx2   : tx1,   frame_bit(d, k / div));
      check("frame_busy", sel ? busy2 : busy1, 1);
      check("frame_done", sel ? done2 : done1, 0);
      set_di(sel, 8'($urandom));
      if (k == 0) set_start(sel, hold);
      if (k == mid_k) drive(sel, 1'b1, mid_d);
      else if (k == mid_k + 1) set_start(sel, hold);
      step();
    end
    check("end_done", sel ? done2 : done1, 1);
    check("end_busy", sel ? busy2 : busy1, 0);
    check("end_tx",   sel ? tx2   : tx1,   1);
    if (sel) exp_done2++;
    else     exp_done1++;
  endtask

  initial begin
    bit prev_hold;
    bit hold;
    int mid;
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    step();
    step();
    check_idle(0, "rst1");
    check_idle(1, "rst2");
    rst = 1'b1;
    idle(0, 2);

    run_frame(0, 8'hA5, 0, -1, 8'h00);
    idle(0, 1);
    run_frame(0, 8'h3C, 0, 13, 8'h00);
    idle(0, 2);
    run_frame(0, 8'h55, 1, -1, 8'h00);
    run_frame(0, 8'h0F, 0, -1, 8'h00);
    idle(0, 1);
    run_frame(0, 8'h07, 0, -1, 8'h00);
    idle(0, 1);
    run_frame(0, 8'h03, 0, -1, 8'h00);
    idle(0, 1);

    drive(0, 1'b1, 8'h5A);
    step();
    set_start(0, 1'b0);
    repeat (4 + 5) step();
    check("mid_busy_pre", busy1, 1);
    rst = 1'b0;
    #1;
    check_idle(0, "rst_mid");
    step();
    step();
    check_idle(0, "rst_hold");
    rst = 1'b1;
    idle(0, 2);
    run_frame(0, 8'hFF, 0, -1, 8'h00);
    idle(0, 1);

    prev_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!prev_hold) idle(0, $urandom_range(0, 3));
      hold = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      mid  = $urandom_range(0, 1) ? $urandom_range(1, NB * 4 - 2) : -1;
      run_frame(0, 8'($urandom), hold, mid, 8'($urandom));
      prev_hold = hold;
    end
    idle(0, 2);

    idle(1, 1);
    run_frame(1, 8'h81, 0, -1, 8'h00);
    idle(1, 1);
    run_frame(1, 8'($urandom), 1, -1, 8'h00);
    run_frame(1, 8'($urandom), 0, 5, 8'($urandom));
    idle(1, 3);

    check("done_cnt1", n_done1, exp_done1);
    check("done_cnt2", n_done2, exp_done2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
